// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam int unsigned BIT_CNT_W       = $clog2(FRAME_DATA_BITS);
    localparam logic        START_BIT       = 1'b0;
    localparam logic        STOP_BIT        = 1'b1;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                           input logic                       par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Line synchroniser and falling-edge strobe for the PS/2 clock/data pair.
// Optional glitch filter on the line clock when PS2_RX_FILTER_EN is defined.
module ps2_sync_edge #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic edge_o,
    output logic dat_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       level;
    logic       level_prev_q;
    logic       edge_q;
    logic       dat_q;

`ifdef PS2_RX_FILTER_EN
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] flt_cnt_q, flt_cnt_d;
    logic          flt_q, flt_d;

    // Level follows the synced clock only after FILTER_LEN consecutive differing samples.
    always_comb begin
        flt_d     = flt_q;
        flt_cnt_d = '0;
        if (clk_sync_q[1] != flt_q) begin
            if (flt_cnt_q == CW'(FILTER_LEN - 1)) begin
                flt_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flt_q     <= 1'b1;
            flt_cnt_q <= '0;
        end else begin
            flt_q     <= flt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign level = flt_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = (FILTER_LEN == 0);
    assign level             = clk_sync_q[1];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            level_prev_q <= 1'b1;
            edge_q       <= 1'b0;
            dat_q        <= 1'b1;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q   <= {dat_sync_q[0], ps2_dat_i};
            level_prev_q <= level;
            edge_q       <= level_prev_q & ~level;
            dat_q        <= dat_sync_q[1];
        end
    end

    assign edge_o = edge_q;
    assign dat_o  = dat_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 host-side receiver: deframes start/8 data/odd parity/stop into a
// valid/ready byte port with one-cycle error pulses. Option: PS2_RX_FILTER_EN.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       overrun
);

    localparam int unsigned          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]        TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_DATA_BITS - 1);

    // Reset asserts immediately but releases on a clock edge.
    logic rst_meta_q, rst_int_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_int_q  <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_int_q  <= rst_meta_q;
        end
    end

    logic line_edge;
    logic line_dat;

    ps2_sync_edge #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync_edge (
        .clk_i    (clk),
        .rst_i    (rst_int_q),
        .ps2_clk_i(ps2_clk),
        .ps2_dat_i(ps2_dat),
        .edge_o   (line_edge),
        .dat_o    (line_dat)
    );

    ps2_state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic                       par_q, par_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [7:0]                 data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;
    logic                       terr_q, terr_d;
    logic                       ovr_q, ovr_d;
    logic                       good;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        terr_d    = 1'b0;
        ovr_d     = 1'b0;
        good      = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        if (state_q == IDLE || line_edge) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (line_edge && line_dat == START_BIT) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (line_edge) begin
                    shift_d = {line_dat, shift_q[FRAME_DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (line_edge) begin
                    par_d   = line_dat;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (line_edge) begin
                    state_d = IDLE;
                    if (line_dat != STOP_BIT) begin
                        ferr_d = 1'b1;
                    end else if (!odd_parity_ok(shift_q, par_q)) begin
                        perr_d = 1'b1;
                    end else begin
                        good = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort the partial frame once the gap since the last edge reaches the limit.
        if (state_q != IDLE && !line_edge && tmo_d == TMO_MAX) begin
            state_d = IDLE;
            terr_d  = 1'b1;
            tmo_d   = '0;
        end

        if (good) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_int_q) begin
        if (rst_int_q) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            terr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            terr_q    <= terr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign err_parity  = perr_q;
    assign err_frame   = ferr_q;
    assign err_timeout = terr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx; build with PS2_RX_FILTER_EN to include the glitch case.
module tb_ps2_rx;

    localparam int unsigned TMO = 400;
    localparam int unsigned FL  = 8;
`ifdef PS2_RX_FILTER_EN
    localparam int LAT = 4 + FL;
`else
    localparam int LAT = 4;
`endif
    localparam int H = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       err_parity;
    logic       err_frame;
    logic       err_timeout;
    logic       overrun;

    ps2_rx #(
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .err_timeout(err_timeout),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int       cyc = 0;
    int       acc_cnt = 0;
    logic [7:0] acc_last = '0;
    int       valid_cycles = 0;
    logic     prev_valid = 1'b0;
    int       rise_cyc = 0;
    int       n_par = 0, n_frm = 0, n_tmo = 0, n_ovr = 0;
    int       tmo_cyc = 0;
    int       fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_valid <= rx_valid;
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        if (rx_valid) valid_cycles <= valid_cycles + 1;
        if (rx_valid && rx_ready) begin
            acc_cnt  <= acc_cnt + 1;
            acc_last <= rx_data;
        end
        if (err_parity) n_par <= n_par + 1;
        if (err_frame) n_frm <= n_frm + 1;
        if (err_timeout) begin
            n_tmo   <= n_tmo + 1;
            tmo_cyc <= cyc;
        end
        if (overrun) n_ovr <= n_ovr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line_bit(input logic b, input int half);
        ps2_dat = b;
        wait_cyc(half);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        wait_cyc(half);
        ps2_clk = 1'b1;
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // Returns the cycle of the stop-bit falling edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int half, output int stop_fall);
        line_bit(1'b0, half);
        for (int i = 0; i < 8; i++) line_bit(d[i], half);
        line_bit(p, half);
        line_bit(s, half);
        stop_fall = fall_cyc;
        ps2_dat = 1'b1;
        wait_cyc(2 * half);
    endtask

    int a0, v0, p0, f0, t0, o0, sf, last_fall;

    task automatic snap();
        a0 = acc_cnt; v0 = valid_cycles; p0 = n_par; f0 = n_frm; t0 = n_tmo; o0 = n_ovr;
    endtask

    task automatic chk_no_err(input string tag);
        chk(tag, (n_par - p0) + (n_frm - f0) + (n_tmo - t0) + (n_ovr - o0), 0);
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rx_ready = 1'b1;
        wait_cyc(5);
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_pulses", {err_parity, err_frame, err_timeout, overrun}, 0);
        rst = 1'b0;
        wait_cyc(5);

        // Good byte with immediate consumer
        snap();
        send_frame(8'hA5, 1'b1, 1'b1, H, sf);
        chk("a5_accepted", acc_cnt - a0, 1);
        chk("a5_data", acc_last, 8'hA5);
        chk("a5_valid_len", valid_cycles - v0, 1);
        chk("a5_latency", rise_cyc - sf, LAT);
        chk_no_err("a5_no_err");

        // Bad parity
        snap();
        send_frame(8'h3C, 1'b0, 1'b1, H, sf);
        chk("3c_par_err", n_par - p0, 1);
        chk("3c_par_no_frm", n_frm - f0, 0);
        chk("3c_par_no_valid", valid_cycles - v0, 0);

        // Bad stop outranks bad parity
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, H, sf);
        chk("3c_frm_err", n_frm - f0, 1);
        chk("3c_frm_no_par", n_par - p0, 0);
        chk("3c_frm_no_valid", valid_cycles - v0, 0);

        // Partial frame then idle line
        snap();
        line_bit(1'b0, H);
        line_bit(1'b1, H);
        line_bit(1'b0, H);
        line_bit(1'b1, H);
        last_fall = fall_cyc;
        for (int i = 0; i < 2 * TMO && n_tmo == t0; i++) wait_cyc(1);
        chk("tmo_pulse", n_tmo - t0, 1);
        chk("tmo_delay", tmo_cyc - last_fall, TMO + LAT);
        snap();
        send_frame(8'h12, odd_par(8'h12), 1'b1, H, sf);
        chk("after_tmo_data", acc_last, 8'h12);
        chk("after_tmo_cnt", acc_cnt - a0, 1);
        chk_no_err("after_tmo_no_err");

        // Stalled consumer, second byte overruns
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, odd_par(8'h11), 1'b1, H, sf);
        chk("ovr_first_valid", rx_valid, 1);
        chk("ovr_first_data", rx_data, 8'h11);
        send_frame(8'h22, odd_par(8'h22), 1'b1, H, sf);
        chk("ovr_pulse", n_ovr - o0, 1);
        chk("ovr_held_data", rx_data, 8'h11);
        chk("ovr_none_taken", acc_cnt - a0, 0);
        rx_ready = 1'b1;
        @(negedge clk);
        chk("ovr_valid_same_cycle", rx_valid, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ovr_valid_drop", rx_valid, 0);
        wait_cyc(1);
        chk("ovr_taken_data", acc_last, 8'h11);
        chk("ovr_taken_cnt", acc_cnt - a0, 1);

        // Reset in the middle of a frame
        line_bit(1'b0, H);
        for (int i = 0; i < 4; i++) line_bit(1'b1, H);
        rst = 1'b1;
        wait_cyc(3);
        chk("midrst_valid", rx_valid, 0);
        rst = 1'b0;
        wait_cyc(5);
        snap();
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, H, sf);
        chk("midrst_cnt", acc_cnt - a0, 1);
        chk("midrst_data", acc_last, 8'h5A);
        chk_no_err("midrst_no_err");

`ifdef PS2_RX_FILTER_EN
        // Short low glitch on the line clock must not start a frame
        snap();
        ps2_dat = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(2);
        ps2_dat = 1'b1;
        wait_cyc(20);
        chk("glitch_no_valid", valid_cycles - v0, 0);
        chk_no_err("glitch_no_err");
`endif

        // Two line-clock rates
        snap();
        send_frame(8'h80, odd_par(8'h80), 1'b1, 50, sf);
        chk("slow_data", acc_last, 8'h80);
        chk("slow_latency", rise_cyc - sf, LAT);
        send_frame(8'h80, odd_par(8'h80), 1'b1, 30, sf);
        chk("fast_cnt", acc_cnt - a0, 2);
        chk("fast_latency", rise_cyc - sf, LAT);
        chk_no_err("speeds_no_err");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
